// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Initiator side of the instruction-memory read interface. Owns the PC,
//   drives a registered word address into a combinational instruction
//   memory, and buffers up to two fetched words toward decode over a
//   valid/ready handshake. Halts on an all-ones opcode and accepts
//   branch/jump redirects from execute in any state.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_addr   [31:0]  registered byte address to instruction memory
//   imem_instr  [31:0]  instruction word returned for imem_addr (same cycle)
//   redirect_valid      PC change request (sampled on rising clk)
//   redirect_pc [31:0]  redirect target; bits [1:0] ignored
//   out_valid           head of queue holds an instruction
//   out_ready           decode accepts the head this cycle
//   out_instr   [31:0]  head instruction word
//   out_pc      [31:0]  address the head was fetched from
//   out_opcode  [5:0]   out_instr[31:26]
//   out_funcode [5:0]   out_instr[5:0]
//   halted              fetch stopped on a halt word and queue drained
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] INIT_ADDR = 32'hFFFF_FFFC,
    parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [5:0]  out_opcode,
    output logic [5:0]  out_funcode,
    output logic        halted
);

    typedef enum logic [1:0] {S_INIT, S_FETCH, S_HALT} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_nxt;
    logic [1:0]  count, count_nxt;
    // Two-entry FIFO kept as a shift pair: head is always slot 0.
    logic [31:0] head_pc, head_instr, tail_pc, tail_instr;
    logic [31:0] head_pc_nxt, head_instr_nxt, tail_pc_nxt, tail_instr_nxt;
    logic        pop, push, space, is_halt;
    logic        unused_ok;

    assign unused_ok = ^redirect_pc[1:0];

    assign is_halt = (imem_instr[31:26] == 6'b111111);
    assign pop     = (count != 2'd0) && out_ready;
    assign space   = (count < 2'd2) || pop;
    assign push    = (state == S_FETCH) && space && !redirect_valid;

    always_comb begin
        state_nxt      = state;
        addr_nxt       = imem_addr;
        count_nxt      = count;
        head_pc_nxt    = head_pc;
        head_instr_nxt = head_instr;
        tail_pc_nxt    = tail_pc;
        tail_instr_nxt = tail_instr;

        if (redirect_valid) begin
            state_nxt = S_FETCH;
            addr_nxt  = {redirect_pc[31:2], 2'b00};
            count_nxt = 2'd0;
        end else begin
            unique case (state)
                S_INIT: begin
                    state_nxt = S_FETCH;
                    addr_nxt  = RESET_PC;
                end
                S_FETCH: begin
                    if (push) begin
                        if (is_halt) state_nxt = S_HALT;
                        else         addr_nxt  = imem_addr + 32'd4;
                    end
                end
                default: ;
            endcase

            if (pop && push) begin
                if (count == 2'd2) begin
                    head_pc_nxt    = tail_pc;
                    head_instr_nxt = tail_instr;
                    tail_pc_nxt    = imem_addr;
                    tail_instr_nxt = imem_instr;
                end else begin
                    head_pc_nxt    = imem_addr;
                    head_instr_nxt = imem_instr;
                end
            end else if (pop) begin
                head_pc_nxt    = tail_pc;
                head_instr_nxt = tail_instr;
                count_nxt      = count - 2'd1;
            end else if (push) begin
                if (count == 2'd0) begin
                    head_pc_nxt    = imem_addr;
                    head_instr_nxt = imem_instr;
                end else begin
                    tail_pc_nxt    = imem_addr;
                    tail_instr_nxt = imem_instr;
                end
                count_nxt = count + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_INIT;
            imem_addr  <= INIT_ADDR;
            count      <= 2'd0;
            head_pc    <= INIT_ADDR;
            head_instr <= HALT_WORD;
            tail_pc    <= INIT_ADDR;
            tail_instr <= HALT_WORD;
        end else begin
            state      <= state_nxt;
            imem_addr  <= addr_nxt;
            count      <= count_nxt;
            head_pc    <= head_pc_nxt;
            head_instr <= head_instr_nxt;
            tail_pc    <= tail_pc_nxt;
            tail_instr <= tail_instr_nxt;
        end
    end

    assign out_valid   = (count != 2'd0);
    assign out_instr   = head_instr;
    assign out_pc      = head_pc;
    assign out_opcode  = head_instr[31:26];
    assign out_funcode = head_instr[5:0];
    assign halted      = (state == S_HALT) && (count == 2'd0);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] INIT_ADDR = 32'hFFFF_FFFC;
    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr, imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_instr, out_pc;
    logic [5:0]  out_opcode, out_funcode;
    logic        halted;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .RESET_PC (RESET_PC),
        .INIT_ADDR(INIT_ADDR),
        .HALT_WORD(HALT_WORD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_opcode    (out_opcode),
        .out_funcode   (out_funcode),
        .halted        (halted)
    );

    // Instruction memory: small program at 0, a plain word below the -4
    // address, halt at -4, and an address-derived non-halt word elsewhere.
    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2001_0005;
            32'h0000_0004: return 32'h0000_0020;
            32'h0000_0008: return HALT_WORD;
            32'hFFFF_FFF8: return 32'h1234_5678;
            32'hFFFF_FFFC: return HALT_WORD;
            default:       return {2'b00, a[29:0]};
        endcase
    endfunction

    assign imem_instr = memf(imem_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".valid"},   {31'd0, out_valid}, 32'd0);
        chk({tag, ".addr"},    imem_addr, INIT_ADDR);
        chk({tag, ".instr"},   out_instr, HALT_WORD);
        chk({tag, ".pc"},      out_pc, INIT_ADDR);
        chk({tag, ".opcode"},  {26'd0, out_opcode}, 32'h3F);
        chk({tag, ".funcode"}, {26'd0, out_funcode}, 32'd0);
        chk({tag, ".halted"},  {31'd0, halted}, 32'd0);
    endtask

    // Hold reset for two edges, check reset values, release on a falling edge.
    task automatic do_reset(input logic rdy);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = rdy;
        repeat (2) @(negedge clk);
        chk_reset_state("rst");
        rst_n = 1'b1;
    endtask

    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc = rpc;
        out_ready = rdy;
        @(negedge clk);
    endtask

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] eaddr;
        logic        eh;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic ev,
                                input logic [31:0] epc, input logic [31:0] ei,
                                input logic [31:0] ea, input logic eh);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = 1'b1; v.ev = ev; v.epc = epc;
        v.einstr = ei; v.eaddr = ea; v.eh = eh;
        return v;
    endfunction

    // Behavioural reference: a PC, a mode and a queue of fetched entries.
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        mq[$];
    logic [31:0] mpc;
    int          mmode; // 0 init, 1 fetching, 2 halted

    task automatic model_step(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic [31:0] w;
        ent_t e;
        if (mq.size() > 0 && rdy) void'(mq.pop_front());
        if (rv) begin
            mq.delete();
            mpc = {rpc[31:2], 2'b00};
            mmode = 1;
        end else if (mmode == 0) begin
            mpc = RESET_PC;
            mmode = 1;
        end else if (mmode == 1 && mq.size() < 2) begin
            w = memf(mpc);
            e.pc = mpc;
            e.instr = w;
            mq.push_back(e);
            if (w[31:26] == 6'b111111) mmode = 2;
            else mpc = mpc + 32'd4;
        end
    endtask

    initial begin
        logic        rv, rdy;
        logic [31:0] rpc;
        logic [31:0] ep, ei;

        // ---------- table: reset program, redirect out of halt, wrap ----------
        vt.push_back(mk(0, 0, 0, 0, 0, 32'h0, 0));
        vt.push_back(mk(0, 0, 1, 32'h0, 32'h2001_0005, 32'h4, 0));
        vt.push_back(mk(0, 0, 1, 32'h4, 32'h0000_0020, 32'h8, 0));
        vt.push_back(mk(0, 0, 1, 32'h8, HALT_WORD, 32'h8, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 32'h8, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 32'h8, 1));
        vt.push_back(mk(1, 32'h0, 0, 0, 0, 32'h0, 0));
        vt.push_back(mk(0, 0, 1, 32'h0, 32'h2001_0005, 32'h4, 0));
        vt.push_back(mk(0, 0, 1, 32'h4, 32'h0000_0020, 32'h8, 0));
        vt.push_back(mk(0, 0, 1, 32'h8, HALT_WORD, 32'h8, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 32'h8, 1));
        vt.push_back(mk(1, 32'hFFFF_FFF8, 0, 0, 0, 32'hFFFF_FFF8, 0));
        vt.push_back(mk(0, 0, 1, 32'hFFFF_FFF8, 32'h1234_5678, 32'hFFFF_FFFC, 0));
        vt.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, HALT_WORD, 32'hFFFF_FFFC, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1));

        @(negedge clk);
        do_reset(1'b1);
        foreach (vt[i]) begin
            step(vt[i].rv, vt[i].rpc, vt[i].rdy);
            chk($sformatf("tbl%0d.valid", i), {31'd0, out_valid}, {31'd0, vt[i].ev});
            chk($sformatf("tbl%0d.addr", i), imem_addr, vt[i].eaddr);
            chk($sformatf("tbl%0d.halted", i), {31'd0, halted}, {31'd0, vt[i].eh});
            if (vt[i].ev) begin
                ep = vt[i].epc;
                ei = vt[i].einstr;
                chk($sformatf("tbl%0d.pc", i), out_pc, ep);
                chk($sformatf("tbl%0d.instr", i), out_instr, ei);
                chk($sformatf("tbl%0d.opcode", i), {26'd0, out_opcode}, {26'd0, ei[31:26]});
                chk($sformatf("tbl%0d.funcode", i), {26'd0, out_funcode}, {26'd0, ei[5:0]});
            end
        end

        // ---------- back-pressure ----------
        do_reset(1'b0);
        repeat (5) step(0, 0, 0);
        chk("bp.addr", imem_addr, 32'h8);
        chk("bp.pc", out_pc, 32'h0);
        chk("bp.valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        chk("bp.rel0", out_pc, 32'h0);
        step(0, 0, 1);
        chk("bp.rel1", out_pc, 32'h4);
        chk("bp.rel1v", {31'd0, out_valid}, 32'd1);
        step(0, 0, 1);
        chk("bp.rel2", out_pc, 32'h8);
        chk("bp.rel2v", {31'd0, out_valid}, 32'd1);
        step(0, 0, 1);
        chk("bp.drainv", {31'd0, out_valid}, 32'd0);
        chk("bp.halted", {31'd0, halted}, 32'd1);

        // ---------- redirect while full, with pop ----------
        do_reset(1'b0);
        repeat (3) step(0, 0, 0);
        chk("rf.full_addr", imem_addr, 32'h8);
        chk("rf.full_pc", out_pc, 32'h0);
        step(1, 32'h0000_0013, 1);
        chk("rf.valid0", {31'd0, out_valid}, 32'd0);
        chk("rf.addr", imem_addr, 32'h10);
        step(0, 0, 1);
        chk("rf.valid1", {31'd0, out_valid}, 32'd1);
        chk("rf.pc", out_pc, 32'h10);

        // ---------- async reset mid-stream ----------
        do_reset(1'b0);
        repeat (3) step(0, 0, 0);
        chk("ar.full_addr", imem_addr, 32'h8);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_state("ar");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 1);
        chk("ar.addr", imem_addr, RESET_PC);
        chk("ar.v0", {31'd0, out_valid}, 32'd0);
        step(0, 0, 1);
        chk("ar.v1", {31'd0, out_valid}, 32'd1);
        chk("ar.pc", out_pc, RESET_PC);

        // ---------- randomized against reference model ----------
        do_reset(1'b1);
        mq.delete();
        mpc = INIT_ADDR;
        mmode = 0;
        for (int c = 0; c < 600; c++) begin
            chk("rnd.valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
            chk("rnd.addr", imem_addr, mpc);
            chk("rnd.halted", {31'd0, halted}, {31'd0, (mmode == 2) && (mq.size() == 0)});
            if (mq.size() > 0) begin
                chk("rnd.pc", out_pc, mq[0].pc);
                chk("rnd.instr", out_instr, mq[0].instr);
            end
            rv = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       rpc = 32'h0000_0000 | 32'($urandom_range(0, 3));
                1:       rpc = 32'h0000_0100 + 32'($urandom_range(0, 255));
                2:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: rpc = $urandom;
            endcase
            rdy = ($urandom_range(0, 2) != 0);
            model_step(rv, rpc, rdy);
            step(rv, rpc, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
